// File: rtl/mandelbrot_scan_ctrl.sv
// Raster-order frame scan sequencer for the Mandelbrot iteration core.
// Issues one pixel at a time, waits for its escape count and re-emits it as a pixel stream.
module mandelbrot_scan_ctrl #(
  parameter int unsigned BITWIDTH = 11,
  parameter int unsigned CTRWIDTH = 7,
  parameter int unsigned COLS     = 32,
  parameter int unsigned ROWS     = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [BITWIDTH-1:0] cfg_x0,
  input  logic [BITWIDTH-1:0] cfg_y0,
  input  logic [BITWIDTH-1:0] cfg_step,
  input  logic [CTRWIDTH-1:0] cfg_max_iter,
  output logic                core_start,
  output logic [BITWIDTH-1:0] core_cr,
  output logic [BITWIDTH-1:0] core_ci,
  output logic [CTRWIDTH-1:0] core_max_iter,
  input  logic                core_done,
  input  logic [CTRWIDTH-1:0] core_ctr,
  output logic [CTRWIDTH-1:0] ctr_out,
  output logic                new_ctr,
  output logic                frame_start
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t              r_state;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [BITWIDTH-1:0] r_x;
  logic [BITWIDTH-1:0] r_y;
  logic [BITWIDTH-1:0] r_x0;
  logic [BITWIDTH-1:0] r_step;

  logic w_resume;
  logic w_last_col;
  logic w_last_pix;

  // A non-zero position means a frame was interrupted and must be resumed, not reloaded.
  assign w_resume   = (r_col != '0) || (r_row != '0);
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_pix = w_last_col && (r_row == LAST_ROW);

  assign core_cr = r_x;
  assign core_ci = r_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_x0          <= '0;
      r_step        <= '0;
      core_max_iter <= '0;
      core_start    <= 1'b0;
      ctr_out       <= '0;
      new_ctr       <= 1'b0;
      frame_start   <= 1'b0;
    end else begin
      core_start  <= 1'b0;
      new_ctr     <= 1'b0;
      frame_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            if (w_resume) begin
              r_state    <= S_ISSUE;
              core_start <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_x0          <= cfg_x0;
          r_step        <= cfg_step;
          core_max_iter <= cfg_max_iter;
          r_x           <= cfg_x0;
          r_y           <= cfg_y0;
          r_col         <= '0;
          r_row         <= '0;
          r_state       <= S_ISSUE;
          core_start    <= 1'b1;
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            ctr_out     <= core_ctr;
            new_ctr     <= 1'b1;
            frame_start <= !w_resume;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          // Step to the next pixel; coordinates wrap silently modulo 2^BITWIDTH.
          if (!w_last_col) begin
            r_col <= r_col + COL_W'(1);
            r_x   <= r_x + r_step;
          end else begin
            r_col <= '0;
            r_x   <= r_x0;
            r_y   <= r_y - r_step;
            r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
          end
          if (w_last_pix) begin
            r_state <= run ? S_LOAD : S_IDLE;
          end else if (run) begin
            r_state    <= S_ISSUE;
            core_start <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
